pipe_ctrl: RTL and testbench

Pipeline control unit for the 5-stage RISC-V core. Collects jump requests from EX, load-use hazards between ID and EX, and multi-cycle busy from the memory/bus side. Sequences the per-stage stall (freeze) and flush (load NOP / zero) controls for PC, IF/ID and ID/EX. Redirects the PC, deferring a jump that collides with a busy stall.

---
 rtl/pipe_ctrl.sv | 164 ++++++++++++++++
 tb/tb_pipe_ctrl.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - pipeline stall/flush sequencer and PC redirect; optional load-use detection under PIPE_CTRL_LOADUSE_EN
module pipe_ctrl #(
    parameter int unsigned FLUSH_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        jump_en_i,
    input  logic [31:0] jump_addr_i,
    input  logic        ex_load_i,
    input  logic [4:0]  ex_rd_addr_i,
    input  logic [4:0]  id_rs1_addr_i,
    input  logic [4:0]  id_rs2_addr_i,
    input  logic        id_rs1_used_i,
    input  logic        id_rs2_used_i,
    input  logic        mem_busy_i,
    output logic        jump_en_o,
    output logic [31:0] jump_addr_o,
    output logic        stall_pc_o,
    output logic        stall_if_id_o,
    output logic        stall_id_ex_o,
    output logic        flush_if_id_o,
    output logic        flush_id_ex_o,
    output logic [31:0] stall_cnt_o
);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_FLUSH,
        ST_BUSY
    } state_e;

    // Remaining flush cycles loaded after the jump cycle itself
    localparam logic [3:0] FLUSH_RELOAD = 4'(FLUSH_CYCLES - 1);
    localparam bit         MULTI_FLUSH  = (FLUSH_CYCLES > 1);

    state_e      state_q, state_d;
    logic [3:0]  flush_cnt_q, flush_cnt_d;
    logic        pend_jump_q, pend_jump_d;
    logic [31:0] pend_addr_q, pend_addr_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic        load_use;

`ifdef PIPE_CTRL_LOADUSE_EN
    // Load in EX whose destination is read by the instruction in ID
    assign load_use = ex_load_i && (ex_rd_addr_i != 5'd0) &&
                      ((id_rs1_used_i && (id_rs1_addr_i == ex_rd_addr_i)) ||
                       (id_rs2_used_i && (id_rs2_addr_i == ex_rd_addr_i)));
`else
    // Core forwards from MEM; hazard inputs are intentionally unused
    logic unused_loaduse;
    assign unused_loaduse = ^{ex_load_i, ex_rd_addr_i, id_rs1_addr_i, id_rs2_addr_i,
                              id_rs1_used_i, id_rs2_used_i};
    assign load_use = 1'b0;
`endif

    // Next-state and combinational stage controls; priority busy > jump > load-use
    always_comb begin
        state_d       = state_q;
        flush_cnt_d   = flush_cnt_q;
        pend_jump_d   = pend_jump_q;
        pend_addr_d   = pend_addr_q;
        jump_en_o     = 1'b0;
        jump_addr_o   = jump_addr_i;
        stall_pc_o    = 1'b0;
        stall_if_id_o = 1'b0;
        stall_id_ex_o = 1'b0;
        flush_if_id_o = 1'b0;
        flush_id_ex_o = 1'b0;
        unique case (state_q)
            ST_RUN: begin
                if (mem_busy_i) begin
                    stall_pc_o    = 1'b1;
                    stall_if_id_o = 1'b1;
                    stall_id_ex_o = 1'b1;
                    state_d       = ST_BUSY;
                    if (jump_en_i) begin
                        pend_jump_d = 1'b1;
                        pend_addr_d = jump_addr_i;
                    end
                end else if (jump_en_i) begin
                    jump_en_o     = 1'b1;
                    flush_if_id_o = 1'b1;
                    flush_id_ex_o = 1'b1;
                    if (MULTI_FLUSH) begin
                        state_d     = ST_FLUSH;
                        flush_cnt_d = FLUSH_RELOAD;
                    end
                end else if (load_use) begin
                    stall_pc_o    = 1'b1;
                    stall_if_id_o = 1'b1;
                    flush_id_ex_o = 1'b1;
                end
            end
            ST_FLUSH: begin
                if (mem_busy_i) begin
                    stall_pc_o    = 1'b1;
                    stall_if_id_o = 1'b1;
                    stall_id_ex_o = 1'b1;
                end else begin
                    flush_if_id_o = 1'b1;
                    flush_id_ex_o = 1'b1;
                    flush_cnt_d   = flush_cnt_q - 4'd1;
                    if (flush_cnt_q <= 4'd1) begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_BUSY: begin
                if (mem_busy_i) begin
                    stall_pc_o    = 1'b1;
                    stall_if_id_o = 1'b1;
                    stall_id_ex_o = 1'b1;
                    if (jump_en_i && !pend_jump_q) begin
                        pend_jump_d = 1'b1;
                        pend_addr_d = jump_addr_i;
                    end
                end else if (pend_jump_q) begin
                    jump_en_o     = 1'b1;
                    jump_addr_o   = pend_addr_q;
                    flush_if_id_o = 1'b1;
                    flush_id_ex_o = 1'b1;
                    pend_jump_d   = 1'b0;
                    if (MULTI_FLUSH) begin
                        state_d     = ST_FLUSH;
                        flush_cnt_d = FLUSH_RELOAD;
                    end else begin
                        state_d = ST_RUN;
                    end
                end else begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    // Performance counter of PC-stall cycles, wraps naturally
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall_pc_o) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    assign stall_cnt_o = stall_cnt_q;

    // State registers; reset drops any pending jump and remaining flush cycles
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_RUN;
            flush_cnt_q <= 4'd0;
            pend_jump_q <= 1'b0;
            pend_addr_q <= 32'd0;
            stall_cnt_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            pend_jump_q <= pend_jump_d;
            pend_addr_q <= pend_addr_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - directed self-checking bench for pipe_ctrl
module tb_pipe_ctrl;

`ifdef PIPE_CTRL_LOADUSE_EN
    localparam bit LU = 1'b1;
`else
    localparam bit LU = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        jump_en_i;
    logic [31:0] jump_addr_i;
    logic        ex_load_i;
    logic [4:0]  ex_rd_addr_i;
    logic [4:0]  id_rs1_addr_i;
    logic [4:0]  id_rs2_addr_i;
    logic        id_rs1_used_i;
    logic        id_rs2_used_i;
    logic        mem_busy_i;
    logic        jump_en_o;
    logic [31:0] jump_addr_o;
    logic        stall_pc_o;
    logic        stall_if_id_o;
    logic        stall_id_ex_o;
    logic        flush_if_id_o;
    logic        flush_id_ex_o;
    logic [31:0] stall_cnt_o;

    int total = 0;
    int bad   = 0;

    pipe_ctrl #(.FLUSH_CYCLES(2)) dut (
        .clk           (clk),
        .rst           (rst),
        .jump_en_i     (jump_en_i),
        .jump_addr_i   (jump_addr_i),
        .ex_load_i     (ex_load_i),
        .ex_rd_addr_i  (ex_rd_addr_i),
        .id_rs1_addr_i (id_rs1_addr_i),
        .id_rs2_addr_i (id_rs2_addr_i),
        .id_rs1_used_i (id_rs1_used_i),
        .id_rs2_used_i (id_rs2_used_i),
        .mem_busy_i    (mem_busy_i),
        .jump_en_o     (jump_en_o),
        .jump_addr_o   (jump_addr_o),
        .stall_pc_o    (stall_pc_o),
        .stall_if_id_o (stall_if_id_o),
        .stall_id_ex_o (stall_id_ex_o),
        .flush_if_id_o (flush_if_id_o),
        .flush_id_ex_o (flush_id_ex_o),
        .stall_cnt_o   (stall_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {jump_en, stall_pc, stall_if_id, stall_id_ex, flush_if_id, flush_id_ex}
    function automatic logic [5:0] ctl();
        return {jump_en_o, stall_pc_o, stall_if_id_o, stall_id_ex_o, flush_if_id_o, flush_id_ex_o};
    endfunction

    task automatic idle();
        jump_en_i     = 1'b0;
        jump_addr_i   = 32'd0;
        ex_load_i     = 1'b0;
        ex_rd_addr_i  = 5'd0;
        id_rs1_addr_i = 5'd0;
        id_rs2_addr_i = 5'd0;
        id_rs1_used_i = 1'b0;
        id_rs2_used_i = 1'b0;
        mem_busy_i    = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle();
        rst = 1'b0;
        #1;
        rst = 1'b1;
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b0;
        #3;
        total++; if (ctl() !== 6'b0) begin bad++; $display("FAIL reset_ctl got=%b want=%b", ctl(), 6'b0); end
        total++; if (jump_addr_o !== 32'd0) begin bad++; $display("FAIL reset_addr got=%h want=%h", jump_addr_o, 32'd0); end
        total++; if (stall_cnt_o !== 32'd0) begin bad++; $display("FAIL reset_cnt got=%0d want=0", stall_cnt_o); end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1;
        total++; if (ctl() !== 6'b0) begin bad++; $display("FAIL release_ctl got=%b want=%b", ctl(), 6'b0); end
        total++; if (stall_cnt_o !== 32'd0) begin bad++; $display("FAIL release_cnt got=%0d want=0", stall_cnt_o); end
    endtask

    task automatic test_jump();
        do_reset();
        @(negedge clk);
        jump_en_i = 1'b1; jump_addr_i = 32'h0000_0100;
        #1;
        total++; if (ctl() !== 6'b100011) begin bad++; $display("FAIL jump_c0_ctl got=%b want=%b", ctl(), 6'b100011); end
        total++; if (jump_addr_o !== 32'h100) begin bad++; $display("FAIL jump_c0_addr got=%h want=%h", jump_addr_o, 32'h100); end
        @(negedge clk);
        jump_en_i = 1'b1; jump_addr_i = 32'h0000_0400;
        #1;
        total++; if (ctl() !== 6'b000011) begin bad++; $display("FAIL jump_c1_ctl got=%b want=%b", ctl(), 6'b000011); end
        @(negedge clk);
        idle();
        #1;
        total++; if (ctl() !== 6'b0) begin bad++; $display("FAIL jump_c2_ctl got=%b want=%b", ctl(), 6'b0); end
    endtask

    task automatic test_load_use();
        logic [5:0] exp;
        do_reset();
        @(negedge clk);
        ex_load_i = 1'b1; ex_rd_addr_i = 5'd5; id_rs2_addr_i = 5'd5; id_rs2_used_i = 1'b1;
        #1;
        exp = LU ? 6'b011001 : 6'b0;
        total++; if (ctl() !== exp) begin bad++; $display("FAIL lu_bubble got=%b want=%b", ctl(), exp); end
        @(negedge clk);
        idle();
        #1;
        total++; if (ctl() !== 6'b0) begin bad++; $display("FAIL lu_after got=%b want=%b", ctl(), 6'b0); end
        total++; if (stall_cnt_o !== (LU ? 32'd1 : 32'd0)) begin bad++; $display("FAIL lu_cnt got=%0d want=%0d", stall_cnt_o, LU ? 1 : 0); end
        @(negedge clk);
        ex_load_i = 1'b1; ex_rd_addr_i = 5'd0; id_rs2_addr_i = 5'd0; id_rs2_used_i = 1'b1;
        #1;
        total++; if (ctl() !== 6'b0) begin bad++; $display("FAIL lu_x0 got=%b want=%b", ctl(), 6'b0); end
        @(negedge clk);
        ex_load_i = 1'b1; ex_rd_addr_i = 5'd7; id_rs1_addr_i = 5'd7; id_rs1_used_i = 1'b0;
        id_rs2_addr_i = 5'd3; id_rs2_used_i = 1'b1;
        #1;
        total++; if (ctl() !== 6'b0) begin bad++; $display("FAIL lu_unused_rs1 got=%b want=%b", ctl(), 6'b0); end
        @(negedge clk);
        id_rs1_used_i = 1'b1;
        #1;
        exp = LU ? 6'b011001 : 6'b0;
        total++; if (ctl() !== exp) begin bad++; $display("FAIL lu_rs1 got=%b want=%b", ctl(), exp); end
        @(negedge clk);
        jump_en_i = 1'b1; jump_addr_i = 32'h0000_0080;
        #1;
        total++; if (ctl() !== 6'b100011) begin bad++; $display("FAIL lu_vs_jump got=%b want=%b", ctl(), 6'b100011); end
        @(negedge clk);
        idle();
    endtask

    task automatic test_busy_deferred();
        do_reset();
        @(negedge clk);
        mem_busy_i = 1'b1; jump_en_i = 1'b1; jump_addr_i = 32'h0000_0200;
        #1;
        total++; if (ctl() !== 6'b011100) begin bad++; $display("FAIL busy_c1 got=%b want=%b", ctl(), 6'b011100); end
        @(negedge clk);
        jump_en_i = 1'b1; jump_addr_i = 32'h0000_0300;
        #1;
        total++; if (ctl() !== 6'b011100) begin bad++; $display("FAIL busy_c2 got=%b want=%b", ctl(), 6'b011100); end
        @(negedge clk);
        jump_en_i = 1'b0; jump_addr_i = 32'd0;
        #1;
        total++; if (ctl() !== 6'b011100) begin bad++; $display("FAIL busy_c3 got=%b want=%b", ctl(), 6'b011100); end
        @(negedge clk);
        idle();
        #1;
        total++; if (ctl() !== 6'b100011) begin bad++; $display("FAIL busy_issue got=%b want=%b", ctl(), 6'b100011); end
        total++; if (jump_addr_o !== 32'h200) begin bad++; $display("FAIL busy_issue_addr got=%h want=%h", jump_addr_o, 32'h200); end
        total++; if (stall_cnt_o !== 32'd3) begin bad++; $display("FAIL busy_cnt got=%0d want=3", stall_cnt_o); end
        @(negedge clk);
        #1;
        total++; if (ctl() !== 6'b000011) begin bad++; $display("FAIL busy_flush got=%b want=%b", ctl(), 6'b000011); end
        @(negedge clk);
        #1;
        total++; if (ctl() !== 6'b0) begin bad++; $display("FAIL busy_done got=%b want=%b", ctl(), 6'b0); end
    endtask

    task automatic test_busy_reset();
        do_reset();
        @(negedge clk);
        mem_busy_i = 1'b1; jump_en_i = 1'b1; jump_addr_i = 32'h0000_0200;
        @(negedge clk);
        jump_en_i = 1'b0; jump_addr_i = 32'd0;
        #2;
        rst = 1'b0;
        #1;
        total++; if (stall_cnt_o !== 32'd0) begin bad++; $display("FAIL rstbusy_cnt got=%0d want=0", stall_cnt_o); end
        @(negedge clk);
        rst = 1'b1;
        #1;
        total++; if (ctl() !== 6'b011100) begin bad++; $display("FAIL rstbusy_stall got=%b want=%b", ctl(), 6'b011100); end
        @(negedge clk);
        idle();
        #1;
        total++; if (ctl() !== 6'b0) begin bad++; $display("FAIL rstbusy_nojump got=%b want=%b", ctl(), 6'b0); end
        total++; if (stall_cnt_o !== 32'd1) begin bad++; $display("FAIL rstbusy_cnt2 got=%0d want=1", stall_cnt_o); end
    endtask

    task automatic test_busy_load_use();
        do_reset();
        @(negedge clk);
        mem_busy_i = 1'b1;
        ex_load_i = 1'b1; ex_rd_addr_i = 5'd9; id_rs1_addr_i = 5'd9; id_rs1_used_i = 1'b1;
        #1;
        total++; if (ctl() !== 6'b011100) begin bad++; $display("FAIL busylu got=%b want=%b", ctl(), 6'b011100); end
        @(negedge clk);
        idle();
        #1;
        total++; if (ctl() !== 6'b0) begin bad++; $display("FAIL busylu_after got=%b want=%b", ctl(), 6'b0); end
    endtask

    task automatic test_flush_busy();
        do_reset();
        @(negedge clk);
        jump_en_i = 1'b1; jump_addr_i = 32'h0000_0500;
        @(negedge clk);
        idle();
        mem_busy_i = 1'b1;
        #1;
        total++; if (ctl() !== 6'b011100) begin bad++; $display("FAIL flushbusy_hold got=%b want=%b", ctl(), 6'b011100); end
        @(negedge clk);
        mem_busy_i = 1'b0;
        #1;
        total++; if (ctl() !== 6'b000011) begin bad++; $display("FAIL flushbusy_resume got=%b want=%b", ctl(), 6'b000011); end
        @(negedge clk);
        #1;
        total++; if (ctl() !== 6'b0) begin bad++; $display("FAIL flushbusy_done got=%b want=%b", ctl(), 6'b0); end
    endtask

    initial begin
        test_reset();
        test_jump();
        test_load_use();
        test_busy_deferred();
        test_busy_reset();
        test_busy_load_use();
        test_flush_busy();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
